read_store: RTL and testbench
=============================

# read_store

On-chip store for a batch of sequencing reads: the per-read seed descriptors and the 4-bit nucleobase sequences. The block sits at the other end of the SMEM pipeline queue. It feeds the queue a new-read descriptor stream (`new_read_valid`/`new_read` handshake). It also answers the queue's per-cycle base-query requests with a fixed 3-cycle latency. A 64-bit host stream loads the batch before any read is issued.

## Interface
Parameters:
- `MAX_READS`, 1024: reads per batch; `read_num` is 10 bits.
- `READ_SLOTS`, 128: base slots per read, 16 bases per 64-bit word, so 8 words per read.
- `RESP_LAT`, 3: query response latency; fixed, must match the queue's delay line.

Ports:
- `Clk_32UI` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `load_valid` in 1: host beat valid.
- `load_ready` out 1: block accepts the beat.
- `load_data` in 64: header or base beat.
- `load_last` in 1: marks the final base beat of the final read in the batch.
- `batch_clear` in 1: pulse; empties the store and returns to loading.
- `load_done` out 1: batch fully loaded.
- `reads_loaded` out 11: number of reads stored.
- `new_read` in 1: pulse; consumes the presented descriptor.
- `new_read_valid` out 1: descriptor valid.
- `new_read_num` out 10: descriptor field.
- `new_ik_x0`, `new_ik_x1`, `new_ik_x2`, `new_ik_info` out 64 each: descriptor fields.
- `new_forward_i` out 7: descriptor field.
- `query_position_2RAM` in 8: query base position.
- `query_read_num_2RAM` in 10: query read number.
- `query_status_2RAM` in 6: query status.
- `new_read_query_2Queue` out 8: query response.

## Operation
Loader FSM, states HDR, BASES, DONE. Reset state is HDR.
- Each read is 5 header beats followed by 8 base beats.
- Header beats 0–3 are `ik_x0`, `ik_x1`, `ik_x2`, `ik_info`.
- Header beat 4 carries `forward_i` in bits [6:0]; its other bits are ignored.
- In a base beat, base k is at bits [4k+3:4k], and the beat lands in RAM word {read_num, beat[2:0]}.
- A beat transfers when `load_valid && load_ready`.
- The read's `read_num` is `reads_loaded` at header beat 0. `reads_loaded` increments on base beat 7.
- After base beat 7 the FSM goes to DONE if `load_last` is high or `reads_loaded` reaches `MAX_READS`; otherwise it returns to HDR.
- `load_last` is ignored on any other beat.
- In DONE: `load_ready` is 0 and `load_done` is 1.
- `batch_clear` from any state:
  - returns the FSM to HDR;
  - zeroes `reads_loaded` and `issue_ptr`;
  - deasserts `load_done` and `new_read_valid` the next cycle.
  - RAM contents are not cleared.

Descriptor issue, active only when `load_done` is 1:
- `issue_ptr` indexes the descriptor RAM; the output registers hold the descriptor at `issue_ptr`.
- `new_read_valid` = `load_done` && descriptor registers loaded && `issue_ptr < reads_loaded`.
- On `new_read` while valid: `issue_ptr` increments and `new_read_valid` drops for exactly 1 cycle (descriptor RAM read bubble). It then rises with the next descriptor if one remains.
- `new_read` while not valid is ignored.

Query responder, 3 registered stages:
- Stage 1 registers the word address {read_num, pos[6:4]}, nibble select pos[3:0], and a miss flag.
- Stage 2 does the RAM read.
- Stage 3 selects the nibble and outputs `{4'b0, base}`.
- Miss flag is set when `pos[7]`=1, or `read_num >= reads_loaded`, or `status == 6'h3F` (DONE).
- On a miss the response is `8'hFF`.
- Queries are accepted every cycle, with no stall and no handshake.

## Timing
- Reset values:
  - `load_ready`=0, then 1 from the first cycle after reset release.
  - `load_done`=0, `reads_loaded`=0, `new_read_valid`=0.
  - Descriptor outputs = 0.
  - `new_read_query_2Queue`=`8'hFF`.
- Query presented in cycle t → response valid in cycle t+3, fully pipelined. Back-to-back queries give back-to-back responses.
- First descriptor: `new_read_valid` rises 2 cycles after `load_done` rises.
- Reset asserted mid-load aborts the batch. Stored data is undefined until reloaded.
- Loads and queries use separate RAM ports, so a concurrent query during load returns old or new data without a hazard. The queue only queries after `load_done`.

## Structure
- Shared package `smem_pkg` holds:
  - status constants F_init=0, F_run=1, F_break=2, B_init=3, B_run=4, DONE=6'h3F;
  - `BASE_W`=4;
  - `MISS_CODE`=8'hFF;
  - the descriptor field widths.
- Sub-module `sdp_ram`: simple dual-port RAM with a 1-cycle registered read. It is instantiated twice:
  - bases: 8192×64;
  - descriptors: 1024×263.

## Test plan
- Load 2 reads, second with `load_last`; read 1 bases are 0..15 repeated → `reads_loaded`=2 and `load_done`=1; queries (read 1, pos 0/17/127) → 0x00/0x01/0x0F, each 3 cycles later.
- Queries for pos 128, read_num 5 with 2 loaded, and status 6'h3F → `8'hFF` each.
- Consume descriptors: hold `new_read` high continuously → descriptors with `new_read_num` 0 then 1, 1-cycle gap between them, then `new_read_valid`=0. Check `ik`/`forward_i` fields match the loaded header values.
- Load `MAX_READS` reads with `load_last` never asserted → DONE at the 1024th read; `load_ready` stays 0 afterward.
- 20 consecutive queries with random pos/read_num → 20 consecutive responses in order, matching the model.
- `batch_clear` during issue, then reload 1 read → `reads_loaded`=1 and `new_read_num`=0. Assert reset mid-header → all outputs at their reset values.

Source files
------------

// File: rtl/smem_pkg.sv
// Constants, types and helpers shared by the SMEM read store and the pipeline queue.
package smem_pkg;

    localparam logic [5:0] F_init  = 6'd0;
    localparam logic [5:0] F_run   = 6'd1;
    localparam logic [5:0] F_break = 6'd2;
    localparam logic [5:0] B_init  = 6'd3;
    localparam logic [5:0] B_run   = 6'd4;
    localparam logic [5:0] DONE    = 6'h3F;

    localparam int         BASE_W         = 4;
    localparam logic [7:0] MISS_CODE      = 8'hFF;
    localparam int         IK_W           = 64;
    localparam int         FWD_W          = 7;
    localparam int         READ_NUM_W     = 10;
    localparam int         WORD_W         = 64;
    localparam int         WORDS_PER_READ = 8;
    localparam int         HDR_BEATS      = 5;
    localparam int         RESP_LAT       = 3;
    localparam int         BASE_ADDR_W    = READ_NUM_W + 3;

    typedef struct packed {
        logic [IK_W-1:0]  ik_x0;
        logic [IK_W-1:0]  ik_x1;
        logic [IK_W-1:0]  ik_x2;
        logic [IK_W-1:0]  ik_info;
        logic [FWD_W-1:0] forward_i;
    } desc_t;

    typedef enum logic [1:0] {
        ST_HDR,
        ST_BASES,
        ST_DONE
    } loader_state_e;

    function automatic logic [BASE_W-1:0] baseSel(input logic [WORD_W-1:0] word,
                                                  input logic [3:0]        nib);
        return word[nib*BASE_W +: BASE_W];
    endfunction

endpackage

// File: rtl/read_store_if.sv
// Host load stream, descriptor issue handshake and base-query bus of the read store.
interface read_store_if;
    import smem_pkg::*;

    logic                  load_valid;
    logic                  load_ready;
    logic [WORD_W-1:0]     load_data;
    logic                  load_last;
    logic                  batch_clear;
    logic                  load_done;
    logic [10:0]           reads_loaded;

    logic                  new_read;
    logic                  new_read_valid;
    logic [READ_NUM_W-1:0] new_read_num;
    logic [IK_W-1:0]       new_ik_x0;
    logic [IK_W-1:0]       new_ik_x1;
    logic [IK_W-1:0]       new_ik_x2;
    logic [IK_W-1:0]       new_ik_info;
    logic [FWD_W-1:0]      new_forward_i;

    logic [7:0]            query_position_2RAM;
    logic [READ_NUM_W-1:0] query_read_num_2RAM;
    logic [5:0]            query_status_2RAM;
    logic [7:0]            new_read_query_2Queue;

    modport slave (
        input  load_valid, load_data, load_last, batch_clear, new_read,
               query_position_2RAM, query_read_num_2RAM, query_status_2RAM,
        output load_ready, load_done, reads_loaded, new_read_valid, new_read_num,
               new_ik_x0, new_ik_x1, new_ik_x2, new_ik_info, new_forward_i,
               new_read_query_2Queue
    );

    modport master (
        output load_valid, load_data, load_last, batch_clear, new_read,
               query_position_2RAM, query_read_num_2RAM, query_status_2RAM,
        input  load_ready, load_done, reads_loaded, new_read_valid, new_read_num,
               new_ik_x0, new_ik_x1, new_ik_x2, new_ik_info, new_forward_i,
               new_read_query_2Queue
    );

endinterface

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
module sdp_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/read_store.sv
// Batch store for sequencing reads: host loader, descriptor issue towards the SMEM
// queue, and a fixed three-cycle base-query responder.
module read_store
    import smem_pkg::*;
#(
    parameter int MAX_READS  = 1024,
    parameter int READ_SLOTS = 128
) (
    input  logic        Clk_32UI,
    input  logic        reset_n,
    read_store_if.slave bus
);

    loader_state_e          state_q, state_d;
    logic [2:0]             beat_q, beat_d;
    logic [10:0]            readsLoaded_q, readsLoaded_d;
    logic                   readyEn_q;
    logic [IK_W-1:0]        hdr_q [4];
    logic                   loadFire, loadDone, baseWe, descWe;

    logic [10:0]            issuePtr_q;
    logic                   descLoaded_q, descPending_q;
    desc_t                  desc_q, descWdata;
    logic [$bits(desc_t)-1:0] descRdata;
    logic [READ_NUM_W-1:0]  descRaddr;
    logic                   newReadValid, consume;

    logic [BASE_ADDR_W-1:0] qAddr_q;
    logic [3:0]             qNib_q, qNib2_q;
    logic                   qMiss, qMiss_q, qMiss2_q;
    logic [WORD_W-1:0]      baseRdata;
    logic [7:0]             resp_q;

    assign bus.load_ready = readyEn_q && (state_q != ST_DONE);
    assign loadDone       = (state_q == ST_DONE);
    assign loadFire       = bus.load_valid && bus.load_ready;
    assign descWdata      = {hdr_q[0], hdr_q[1], hdr_q[2], hdr_q[3], bus.load_data[FWD_W-1:0]};

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        readsLoaded_d = readsLoaded_q;
        baseWe        = 1'b0;
        descWe        = 1'b0;
        if (bus.batch_clear) begin
            state_d       = ST_HDR;
            beat_d        = '0;
            readsLoaded_d = '0;
        end else if (loadFire) begin
            unique case (state_q)
                ST_HDR: begin
                    if (beat_q == 3'(HDR_BEATS - 1)) begin
                        descWe  = 1'b1;
                        beat_d  = '0;
                        state_d = ST_BASES;
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end
                ST_BASES: begin
                    baseWe = 1'b1;
                    if (beat_q == 3'(WORDS_PER_READ - 1)) begin
                        beat_d        = '0;
                        readsLoaded_d = readsLoaded_q + 11'd1;
                        state_d       = (bus.load_last || readsLoaded_d == 11'(MAX_READS))
                                        ? ST_DONE : ST_HDR;
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk_32UI or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_HDR;
            beat_q        <= '0;
            readsLoaded_q <= '0;
            readyEn_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            readsLoaded_q <= readsLoaded_d;
            readyEn_q     <= 1'b1;
        end
    end

    // ik words wait here until header beat 4 lets the whole descriptor be written at once.
    always_ff @(posedge Clk_32UI or negedge reset_n) begin
        if (!reset_n) begin
            hdr_q <= '{default: '0};
        end else if (loadFire && state_q == ST_HDR && beat_q < 3'(HDR_BEATS - 1)) begin
            hdr_q[beat_q[1:0]] <= bus.load_data;
        end
    end

    sdp_ram #(.DEPTH(2**BASE_ADDR_W), .WIDTH(WORD_W)) u_base_ram (
        .clk   (Clk_32UI),
        .we    (baseWe),
        .waddr ({readsLoaded_q[READ_NUM_W-1:0], beat_q}),
        .wdata (bus.load_data),
        .raddr (qAddr_q),
        .rdata (baseRdata)
    );

    sdp_ram #(.DEPTH(2**READ_NUM_W), .WIDTH($bits(desc_t))) u_desc_ram (
        .clk   (Clk_32UI),
        .we    (descWe),
        .waddr (readsLoaded_q[READ_NUM_W-1:0]),
        .wdata (descWdata),
        .raddr (descRaddr),
        .rdata (descRdata)
    );

    // On a consume the next descriptor is fetched straight away so the valid gap is one cycle.
    assign newReadValid = loadDone && descLoaded_q && (issuePtr_q < readsLoaded_q);
    assign consume      = bus.new_read && newReadValid;
    assign descRaddr    = issuePtr_q[READ_NUM_W-1:0] + READ_NUM_W'(consume);

    always_ff @(posedge Clk_32UI or negedge reset_n) begin
        if (!reset_n) begin
            issuePtr_q    <= '0;
            descLoaded_q  <= 1'b0;
            descPending_q <= 1'b0;
            desc_q        <= '0;
        end else if (bus.batch_clear) begin
            issuePtr_q    <= '0;
            descLoaded_q  <= 1'b0;
            descPending_q <= 1'b0;
        end else if (consume) begin
            issuePtr_q    <= issuePtr_q + 11'd1;
            descLoaded_q  <= 1'b0;
            descPending_q <= 1'b1;
        end else if (descPending_q) begin
            desc_q        <= desc_t'(descRdata);
            descLoaded_q  <= 1'b1;
            descPending_q <= 1'b0;
        end else if (loadDone && !descLoaded_q) begin
            descPending_q <= 1'b1;
        end
    end

    assign qMiss = (int'(bus.query_position_2RAM) >= READ_SLOTS)
                || ({1'b0, bus.query_read_num_2RAM} >= readsLoaded_q)
                || (bus.query_status_2RAM == DONE);

    always_ff @(posedge Clk_32UI or negedge reset_n) begin
        if (!reset_n) begin
            qAddr_q  <= '0;
            qNib_q   <= '0;
            qMiss_q  <= 1'b1;
            qNib2_q  <= '0;
            qMiss2_q <= 1'b1;
            resp_q   <= MISS_CODE;
        end else begin
            qAddr_q  <= {bus.query_read_num_2RAM, bus.query_position_2RAM[6:4]};
            qNib_q   <= bus.query_position_2RAM[3:0];
            qMiss_q  <= qMiss;
            qNib2_q  <= qNib_q;
            qMiss2_q <= qMiss_q;
            resp_q   <= qMiss2_q ? MISS_CODE : {4'b0, baseSel(baseRdata, qNib2_q)};
        end
    end

    assign bus.load_done             = loadDone;
    assign bus.reads_loaded          = readsLoaded_q;
    assign bus.new_read_valid        = newReadValid;
    assign bus.new_read_num          = issuePtr_q[READ_NUM_W-1:0];
    assign bus.new_ik_x0             = desc_q.ik_x0;
    assign bus.new_ik_x1             = desc_q.ik_x1;
    assign bus.new_ik_x2             = desc_q.ik_x2;
    assign bus.new_ik_info           = desc_q.ik_info;
    assign bus.new_forward_i         = desc_q.forward_i;
    assign bus.new_read_query_2Queue = resp_q;

endmodule

// File: tb/tb_read_store.sv
// Directed bench for read_store: loading, descriptor issue, query latency and misses,
// a full MAX_READS batch, batch_clear and reset mid-load.
module tb_read_store;
    import smem_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checkCount = 0;
    int   passCount  = 0;
    int   failCount  = 0;
    bit   loadStalled = 1'b0;
    int   rn, pos, st;
    logic [7:0] expQ [20];

    always #5 clk = ~clk;

    read_store_if bus();

    read_store dut (
        .Clk_32UI (clk),
        .reset_n  (rst_n),
        .bus      (bus)
    );

    function automatic logic [63:0] hdrWord(input int idx, input int k);
        return {16'hA5A5, 16'(idx), 16'(k), 16'h5A5A};
    endfunction

    function automatic logic [6:0] fwdVal(input int idx);
        return 7'(idx + 33);
    endfunction

    function automatic logic [63:0] baseWord(input int mode, input int j);
        case (mode)
            0:       return 64'h0123_4567_89AB_CDEF ^ 64'(j);
            1:       return 64'hFEDC_BA98_7654_3210;
            default: return {8{8'(j)}};
        endcase
    endfunction

    // Reference for the two-read batch: read 0 uses mode 0, read 1 mode 1.
    function automatic logic [7:0] expQuery(input int qrn, input int qpos, input int qst);
        logic [63:0] word;
        if (qpos >= 128 || qrn >= 2 || qst == 63) return 8'hFF;
        word = baseWord((qrn == 0) ? 0 : 1, qpos / 16);
        return {4'b0, word[(qpos % 16) * 4 +: 4]};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [63:0] data, input logic last);
        int waited = 0;
        if (loadStalled) return;
        bus.load_valid = 1'b1;
        bus.load_data  = data;
        bus.load_last  = last;
        while (bus.load_ready !== 1'b1 && waited < 16) begin
            @(negedge clk);
            waited++;
        end
        if (bus.load_ready !== 1'b1) begin
            loadStalled = 1'b1;
            checkOutput("load_ready_wait", 64'(bus.load_ready), 64'd1);
        end else begin
            @(negedge clk);
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    task automatic loadRead(input int idx, input int mode, input logic lastFlag,
                            input logic strayLast);
        for (int k = 0; k < 4; k++) applyStimulus(hdrWord(idx, k), strayLast);
        applyStimulus({32'hDEAD_BEEF, 25'h1FF_FFFF, fwdVal(idx)}, strayLast);
        for (int j = 0; j < 8; j++) applyStimulus(baseWord(mode, j), (j == 7) ? lastFlag : strayLast);
    endtask

    task automatic queryCheck(input string tag, input int qrn, input int qpos, input int qst,
                              input logic [7:0] expected);
        bus.query_read_num_2RAM = 10'(qrn);
        bus.query_position_2RAM = 8'(qpos);
        bus.query_status_2RAM   = 6'(qst);
        @(negedge clk);
        bus.query_read_num_2RAM = '0;
        bus.query_position_2RAM = 8'h80;
        bus.query_status_2RAM   = 6'd1;
        @(negedge clk);
        @(negedge clk);
        checkOutput(tag, 64'(bus.new_read_query_2Queue), 64'(expected));
    endtask

    task automatic checkDesc(input string tag, input int num, input int idx);
        checkOutput({tag, "_valid"}, 64'(bus.new_read_valid), 64'd1);
        checkOutput({tag, "_num"}, 64'(bus.new_read_num), 64'(num));
        checkOutput({tag, "_x0"}, bus.new_ik_x0, hdrWord(idx, 0));
        checkOutput({tag, "_x1"}, bus.new_ik_x1, hdrWord(idx, 1));
        checkOutput({tag, "_x2"}, bus.new_ik_x2, hdrWord(idx, 2));
        checkOutput({tag, "_info"}, bus.new_ik_info, hdrWord(idx, 3));
        checkOutput({tag, "_fwd"}, 64'(bus.new_forward_i), 64'(fwdVal(idx)));
    endtask

    initial begin
        bus.load_valid          = 1'b0;
        bus.load_data           = '0;
        bus.load_last           = 1'b0;
        bus.batch_clear         = 1'b0;
        bus.new_read            = 1'b0;
        bus.query_position_2RAM = 8'h80;
        bus.query_read_num_2RAM = '0;
        bus.query_status_2RAM   = 6'd1;

        repeat (2) @(negedge clk);
        checkOutput("rst_load_ready", 64'(bus.load_ready), 64'd0);
        checkOutput("rst_load_done", 64'(bus.load_done), 64'd0);
        checkOutput("rst_reads_loaded", 64'(bus.reads_loaded), 64'd0);
        checkOutput("rst_valid", 64'(bus.new_read_valid), 64'd0);
        checkOutput("rst_ik_x0", bus.new_ik_x0, 64'd0);
        checkOutput("rst_resp", 64'(bus.new_read_query_2Queue), 64'hFF);
        rst_n = 1'b1;
        checkOutput("release_ready_low", 64'(bus.load_ready), 64'd0);
        @(negedge clk);
        checkOutput("release_ready_high", 64'(bus.load_ready), 64'd1);

        // Two-read batch; stray load_last on read 0 must be ignored.
        loadRead(0, 0, 1'b0, 1'b1);
        checkOutput("r0_done_low", 64'(bus.load_done), 64'd0);
        checkOutput("r0_reads_loaded", 64'(bus.reads_loaded), 64'd1);
        loadRead(1, 1, 1'b1, 1'b0);
        checkOutput("b2_done", 64'(bus.load_done), 64'd1);
        checkOutput("b2_reads_loaded", 64'(bus.reads_loaded), 64'd2);
        checkOutput("b2_ready_low", 64'(bus.load_ready), 64'd0);
        checkOutput("b2_valid_t0", 64'(bus.new_read_valid), 64'd0);
        @(negedge clk);
        checkOutput("b2_valid_t1", 64'(bus.new_read_valid), 64'd0);
        @(negedge clk);
        checkDesc("desc0", 0, 0);

        queryCheck("q_r1_p0", 1, 0, 1, 8'h00);
        queryCheck("q_r1_p17", 1, 17, 1, 8'h01);
        queryCheck("q_r1_p127", 1, 127, 1, 8'h0F);
        queryCheck("q_r0_p37", 0, 37, 1, 8'h0A);
        queryCheck("q_r0_p112", 0, 112, 4, 8'h08);
        queryCheck("q_pos128", 0, 128, 1, 8'hFF);
        queryCheck("q_read5", 5, 3, 1, 8'hFF);
        queryCheck("q_read2", 2, 3, 1, 8'hFF);
        queryCheck("q_status_done", 1, 0, 63, 8'hFF);

        for (int k = 0; k < 23; k++) begin
            if (k >= 3) checkOutput($sformatf("stream_%0d", k - 3),
                                    64'(bus.new_read_query_2Queue), 64'(expQ[k - 3]));
            if (k < 20) begin
                rn  = $urandom_range(0, 2);
                pos = $urandom_range(0, 143);
                st  = ($urandom_range(0, 7) == 0) ? 63 : $urandom_range(0, 4);
                expQ[k] = expQuery(rn, pos, st);
                bus.query_read_num_2RAM = 10'(rn);
                bus.query_position_2RAM = 8'(pos);
                bus.query_status_2RAM   = 6'(st);
            end else begin
                bus.query_position_2RAM = 8'h80;
            end
            @(negedge clk);
        end

        checkOutput("issue_c0_valid", 64'(bus.new_read_valid), 64'd1);
        bus.new_read = 1'b1;
        @(negedge clk);
        checkOutput("issue_gap", 64'(bus.new_read_valid), 64'd0);
        @(negedge clk);
        checkDesc("desc1", 1, 1);
        @(negedge clk);
        checkOutput("issue_c3_valid", 64'(bus.new_read_valid), 64'd0);
        @(negedge clk);
        checkOutput("issue_empty", 64'(bus.new_read_valid), 64'd0);
        @(negedge clk);
        checkOutput("issue_empty_hold", 64'(bus.new_read_valid), 64'd0);
        bus.new_read = 1'b0;

        bus.batch_clear = 1'b1;
        @(negedge clk);
        bus.batch_clear = 1'b0;
        checkOutput("clr_done", 64'(bus.load_done), 64'd0);
        checkOutput("clr_reads", 64'(bus.reads_loaded), 64'd0);
        checkOutput("clr_ready", 64'(bus.load_ready), 64'd1);

        // Full batch without load_last: the store closes itself at MAX_READS.
        for (int i = 0; i < 1024; i++) begin
            loadRead(i, 2, 1'b0, 1'b0);
            if (i == 1022) begin
                checkOutput("max_m1_done", 64'(bus.load_done), 64'd0);
                checkOutput("max_m1_reads", 64'(bus.reads_loaded), 64'd1023);
            end
        end
        checkOutput("max_done", 64'(bus.load_done), 64'd1);
        checkOutput("max_reads", 64'(bus.reads_loaded), 64'd1024);
        bus.load_valid = 1'b1;
        bus.load_data  = 64'h1234;
        repeat (3) @(negedge clk);
        checkOutput("max_ready_stays_low", 64'(bus.load_ready), 64'd0);
        checkOutput("max_reads_hold", 64'(bus.reads_loaded), 64'd1024);
        bus.load_valid = 1'b0;
        checkDesc("max_desc0", 0, 0);
        bus.new_read = 1'b1;
        @(negedge clk);
        bus.new_read = 1'b0;
        checkOutput("max_gap", 64'(bus.new_read_valid), 64'd0);
        @(negedge clk);
        checkDesc("max_desc1", 1, 1);

        bus.batch_clear = 1'b1;
        @(negedge clk);
        bus.batch_clear = 1'b0;
        checkOutput("clr2_valid", 64'(bus.new_read_valid), 64'd0);
        checkOutput("clr2_done", 64'(bus.load_done), 64'd0);
        checkOutput("clr2_reads", 64'(bus.reads_loaded), 64'd0);

        loadRead(7, 0, 1'b1, 1'b0);
        checkOutput("reload_reads", 64'(bus.reads_loaded), 64'd1);
        checkOutput("reload_done", 64'(bus.load_done), 64'd1);
        repeat (2) @(negedge clk);
        checkDesc("reload_desc", 0, 7);
        queryCheck("reload_q_r0_p37", 0, 37, 2, 8'h0A);
        queryCheck("reload_q_r1", 1, 17, 2, 8'hFF);

        bus.batch_clear = 1'b1;
        @(negedge clk);
        bus.batch_clear = 1'b0;
        applyStimulus(hdrWord(9, 0), 1'b0);
        applyStimulus(hdrWord(9, 1), 1'b0);
        bus.load_valid = 1'b1;
        bus.load_data  = hdrWord(9, 2);
        rst_n = 1'b0;
        @(negedge clk);
        bus.load_valid = 1'b0;
        checkOutput("mid_rst_ready", 64'(bus.load_ready), 64'd0);
        checkOutput("mid_rst_done", 64'(bus.load_done), 64'd0);
        checkOutput("mid_rst_reads", 64'(bus.reads_loaded), 64'd0);
        checkOutput("mid_rst_valid", 64'(bus.new_read_valid), 64'd0);
        checkOutput("mid_rst_num", 64'(bus.new_read_num), 64'd0);
        checkOutput("mid_rst_x0", bus.new_ik_x0, 64'd0);
        checkOutput("mid_rst_info", bus.new_ik_info, 64'd0);
        checkOutput("mid_rst_fwd", 64'(bus.new_forward_i), 64'd0);
        checkOutput("mid_rst_resp", 64'(bus.new_read_query_2Queue), 64'hFF);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_ready", 64'(bus.load_ready), 64'd1);
        checkOutput("post_rst_done", 64'(bus.load_done), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
